// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow flop.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0] a_sr, b_sr, r_sr;
    logic [WIDTH-1:0] a_sr_nx, b_sr_nx, r_sr_nx, diff_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             brw, brw_nx, bout_nx, done_nx;
    logic             d_bit, brw_bit;

    assign d_bit   = a_sr[0] ^ b_sr[0] ^ brw;
    assign brw_bit = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
    assign busy    = (state == SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            cnt   <= '0;
            brw   <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            a_sr  <= a_sr_nx;
            b_sr  <= b_sr_nx;
            r_sr  <= r_sr_nx;
            cnt   <= cnt_nx;
            brw   <= brw_nx;
            diff  <= diff_nx;
            bout  <= bout_nx;
            done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        a_sr_nx  = a_sr;
        b_sr_nx  = b_sr;
        r_sr_nx  = r_sr;
        cnt_nx   = cnt;
        brw_nx   = brw;
        diff_nx  = diff;
        bout_nx  = bout;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    a_sr_nx  = a;
                    b_sr_nx  = b;
                    brw_nx   = bin;
                    cnt_nx   = '0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                // Result bits enter at the MSB so the LSB lands in place after WIDTH shifts.
                a_sr_nx = a_sr >> 1;
                b_sr_nx = b_sr >> 1;
                r_sr_nx = WIDTH'({d_bit, r_sr} >> 1);
                brw_nx  = brw_bit;
                cnt_nx  = cnt + CW'(1);
                if (cnt == LAST) begin
                    diff_nx  = r_sr_nx;
                    bout_nx  = brw_bit;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: WIDTH=4, 1 and 8 instances share one clock;
// drivers push expected results, a negedge monitor pops them on each done pulse.
module tb_serial_subtractor;
    typedef struct {
        logic [31:0] d;
        logic        bo;
        int          t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    exp_t q4[$];
    exp_t q1[$];
    exp_t q8[$];

    logic       s4 = 1'b0, bin4 = 1'b0, busy4, done4, bout4;
    logic [3:0] a4 = '0, b4 = '0, diff4;
    logic       s1 = 1'b0, bin1 = 1'b0, busy1, done1, bout1;
    logic [0:0] a1 = '0, b1 = '0, diff1;
    logic       s8 = 1'b0, bin8 = 1'b0, busy8, done8, bout8;
    logic [7:0] a8 = '0, b8 = '0, diff8;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
    );
    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );
    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    task automatic chk(input string nm, input longint got, input longint want);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, want, cyc);
    endtask

    // Monitor: compare each done against the oldest expectation, flag strays and misses.
    exp_t e;
    always @(negedge clk) begin
        if (done4) begin
            if (q4.size() == 0) chk("w4 unexpected done", done4, 0);
            else begin
                e = q4.pop_front();
                chk("w4 diff", diff4, e.d);
                chk("w4 bout", bout4, e.bo);
                chk("w4 done cycle", cyc, e.t);
            end
        end else if (q4.size() > 0 && cyc > q4[0].t) begin
            chk("w4 done missing", done4, 1);
            void'(q4.pop_front());
        end
        if (done1) begin
            if (q1.size() == 0) chk("w1 unexpected done", done1, 0);
            else begin
                e = q1.pop_front();
                chk("w1 diff", diff1, e.d);
                chk("w1 bout", bout1, e.bo);
                chk("w1 done cycle", cyc, e.t);
            end
        end else if (q1.size() > 0 && cyc > q1[0].t) begin
            chk("w1 done missing", done1, 1);
            void'(q1.pop_front());
        end
        if (done8) begin
            if (q8.size() == 0) chk("w8 unexpected done", done8, 0);
            else begin
                e = q8.pop_front();
                chk("w8 diff", diff8, e.d);
                chk("w8 bout", bout8, e.bo);
                chk("w8 done cycle", cyc, e.t);
            end
        end else if (q8.size() > 0 && cyc > q8[0].t) begin
            chk("w8 done missing", done8, 1);
            void'(q8.pop_front());
        end
    end

    task automatic push4(input int d, input logic bo);
        exp_t x;
        x.d = 32'(d); x.bo = bo; x.t = cyc + 1 + 4;
        q4.push_back(x);
    endtask

    // Issue one WIDTH=4 operation; returns at the negedge of its done cycle.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bi,
                       input int d, input logic bo);
        a4 = a; b4 = b; bin4 = bi; s4 = 1'b1;
        push4(d, bo);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s4 = 1'b0;
            chk("w4 busy during op", busy4, 1);
        end
        @(negedge clk);
        chk("w4 busy in done cycle", busy4, 0);
    endtask

    task automatic op1(input logic a, input logic b, input logic bi, input logic d, input logic bo);
        exp_t x;
        a1 = a; b1 = b; bin1 = bi; s1 = 1'b1;
        x.d = 32'(d); x.bo = bo; x.t = cyc + 2;
        q1.push_back(x);
        @(negedge clk);
        s1 = 1'b0;
        chk("w1 busy during op", busy1, 1);
        @(negedge clk);
        chk("w1 busy in done cycle", busy1, 0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input int d, input logic bo);
        exp_t x;
        a8 = a; b8 = b; bin8 = bi; s8 = 1'b1;
        x.d = 32'(d); x.bo = bo; x.t = cyc + 9;
        q8.push_back(x);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s8 = 1'b0;
            chk("w8 busy during op", busy8, 1);
        end
        @(negedge clk);
        chk("w8 busy in done cycle", busy8, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset busy", busy4, 0);
        chk("reset done", done4, 0);
        chk("reset diff", diff4, 0);
        chk("reset bout", bout4, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic and boundary directed vectors, issued back to back.
        op4(4'd9,  4'd4,  1'b0, 5,  1'b0);
        op4(4'd3,  4'd5,  1'b0, 14, 1'b1);
        op4(4'd0,  4'd0,  1'b1, 15, 1'b1);
        op4(4'd15, 4'd15, 1'b0, 0,  1'b0);
        repeat (2) @(negedge clk);

        // Exhaustive sweep with start held high.
        s4 = 1'b1;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int bi = 0; bi < 2; bi++) begin
                    a4 = 4'(a); b4 = 4'(b); bin4 = 1'(bi);
                    push4((a - b - bi) & 15, (a < b + bi));
                    repeat (5) @(negedge clk);
                end
        s4 = 1'b0;
        repeat (3) @(negedge clk);

        // Start while busy is ignored.
        a4 = 4'd12; b4 = 4'd3; bin4 = 1'b0; s4 = 1'b1;
        push4(9, 1'b0);
        @(negedge clk); s4 = 1'b0;
        @(negedge clk);
        a4 = 4'd1; b4 = 4'd1; s4 = 1'b1;
        @(negedge clk); s4 = 1'b0;
        repeat (10) @(negedge clk);
        chk("w4 no queued op after ignore", q4.size(), 0);

        // Asynchronous reset mid-operation.
        a4 = 4'd6; b4 = 4'd1; bin4 = 1'b0; s4 = 1'b1;
        push4(5, 1'b0);
        @(negedge clk); s4 = 1'b0;
        @(negedge clk);
        chk("w4 busy before abort", busy4, 1);
        chk("w4 diff before abort", diff4, 9);
        #2 rst_n = 1'b0;
        q4.delete();
        #1;
        chk("abort busy", busy4, 0);
        chk("abort done", done4, 0);
        chk("abort diff", diff4, 0);
        chk("abort bout", bout4, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (6) @(negedge clk);
        op4(4'd7, 4'd2, 1'b0, 5, 1'b0);
        @(negedge clk);

        // WIDTH=1 and WIDTH=8 instances.
        op1(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        op1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        op1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        op8(8'h10, 8'h01, 1'b1, 8'h0E, 1'b0);
        op8(8'h00, 8'hFF, 1'b0, 8'h01, 1'b1);
        op8(8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0);

        repeat (12) @(negedge clk);
        chk("w4 queue drained", q4.size(), 0);
        chk("w1 queue drained", q1.size(), 0);
        chk("w8 queue drained", q8.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
